// File: rtl/rk_kbd_pkg.sv
// Shared FSM state, HID constants and key-map entry type for the RK-86 HID keyboard.
package rk_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOD  = 2'd1,
    ST_RSVD = 2'd2,
    ST_KEY  = 2'd3
  } kbd_state_e;

  localparam logic [7:0] ROLLOVER = 8'h01;
  localparam logic [7:0] KEY_F12  = 8'h45;

  localparam int MOD_LCTRL  = 0;
  localparam int MOD_LSHIFT = 1;
  localparam int MOD_LALT   = 2;
  localparam int MOD_RCTRL  = 4;
  localparam int MOD_RSHIFT = 5;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } map_entry_t;

  localparam map_entry_t NO_ENTRY = '{valid: 1'b0, row: 4'd0, col: 3'd0};

  function automatic map_entry_t mk_entry(input logic [3:0] row, input logic [2:0] col);
    map_entry_t e;
    e.valid = 1'b1;
    e.row   = row;
    e.col   = col;
    return e;
  endfunction

endpackage

// File: rtl/rk_kbd_map.sv
// HID usage code to RK-86 matrix position {row, col}; purely combinational.
module rk_kbd_map
  import rk_kbd_pkg::*;
(
  input  logic [7:0] code_i,
  output map_entry_t entry_o
);

  logic [4:0] let_idx_s;
  logic [3:0] dig_idx_s;

  // Letters and digits 1-9 are contiguous runs in both HID and the RK layout.
  assign let_idx_s = 5'(code_i - 8'h03);
  assign dig_idx_s = 4'(code_i - 8'h1D);

  always_comb begin
    entry_o = NO_ENTRY;
    if ((code_i >= 8'h04) && (code_i <= 8'h1D)) begin
      entry_o = mk_entry(4'd4 + {2'b00, let_idx_s[4:3]}, let_idx_s[2:0]);
    end else if ((code_i >= 8'h1E) && (code_i <= 8'h26)) begin
      entry_o = mk_entry(4'd2 + {3'b000, dig_idx_s[3]}, dig_idx_s[2:0]);
    end else begin
      case (code_i)
        8'h4A: entry_o = mk_entry(4'd0, 3'd0);
        8'h4C: entry_o = mk_entry(4'd0, 3'd1);
        8'h29: entry_o = mk_entry(4'd0, 3'd2);
        8'h3A: entry_o = mk_entry(4'd0, 3'd3);
        8'h3B: entry_o = mk_entry(4'd0, 3'd4);
        8'h3C: entry_o = mk_entry(4'd0, 3'd5);
        8'h3D: entry_o = mk_entry(4'd0, 3'd6);
        8'h3E: entry_o = mk_entry(4'd0, 3'd7);
        8'h2B: entry_o = mk_entry(4'd1, 3'd0);
        8'h58: entry_o = mk_entry(4'd1, 3'd1);
        8'h28: entry_o = mk_entry(4'd1, 3'd2);
        8'h2A: entry_o = mk_entry(4'd1, 3'd3);
        8'h50: entry_o = mk_entry(4'd1, 3'd4);
        8'h52: entry_o = mk_entry(4'd1, 3'd5);
        8'h4F: entry_o = mk_entry(4'd1, 3'd6);
        8'h51: entry_o = mk_entry(4'd1, 3'd7);
        8'h27: entry_o = mk_entry(4'd2, 3'd0);
        8'h34: entry_o = mk_entry(4'd3, 3'd2);
        8'h33: entry_o = mk_entry(4'd3, 3'd3);
        8'h36: entry_o = mk_entry(4'd3, 3'd4);
        8'h2D: entry_o = mk_entry(4'd3, 3'd5);
        8'h37: entry_o = mk_entry(4'd3, 3'd6);
        8'h38: entry_o = mk_entry(4'd3, 3'd7);
        8'h35: entry_o = mk_entry(4'd4, 3'd0);
        8'h2F: entry_o = mk_entry(4'd7, 3'd3);
        8'h31: entry_o = mk_entry(4'd7, 3'd4);
        8'h30: entry_o = mk_entry(4'd7, 3'd5);
        8'h2E: entry_o = mk_entry(4'd7, 3'd6);
        8'h2C: entry_o = mk_entry(4'd7, 3'd7);
        // Caps lock sits on a ninth row that only exists when ROWS > 8.
        8'h39: entry_o = mk_entry(4'd8, 3'd0);
        default: entry_o = NO_ENTRY;
      endcase
    end
  end

endmodule

// File: rtl/rk_kbd_hid.sv
// HID boot-report parser building an atomically committed RK-86 key matrix.
// Optional inter-byte timeout abort is enabled by defining RK_KBD_TIMEOUT_EN.
module rk_kbd_hid
  import rk_kbd_pkg::*;
#(
  parameter int         ROWS        = 8,
  parameter int         COLS        = 8,
  parameter int         NKEYS       = 6,
  parameter logic [7:0] HDR         = 8'hFE,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_byte,
  input  logic            rx_stb,
  input  logic [ROWS-1:0] addr,
  output logic [COLS-1:0] odata,
  output logic [2:0]      shift,
  output logic            k_reset,
  output logic            frame_err
);

  localparam int SLOT_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NKEYS - 1);

  kbd_state_e                 state_q, state_d;
  logic [2:0]                 mod_q, mod_d;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [ROWS-1:0][COLS-1:0]  shadow_q, shadow_d;
  logic                       err_q, err_d;
  logic                       srst_q, srst_d;
  logic [ROWS-1:0][COLS-1:0]  matrix_q, matrix_d;
  logic [2:0]                 shift_q, shift_d;
  logic                       k_reset_q, k_reset_d;
  logic                       frame_err_q, frame_err_d;
  logic [ROWS-1:0][COLS-1:0]  key_bits_s;
  logic                       timeout_s;
  map_entry_t                 entry_s;

  rk_kbd_map u_map (
    .code_i  (rx_byte),
    .entry_o (entry_s)
  );

  // Single-bit image of the current byte; out-of-range rows/cols never match.
  always_comb begin
    key_bits_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        key_bits_s[r][c] = entry_s.valid && (entry_s.row == 4'(r)) && (entry_s.col == 3'(c));
      end
    end
  end

`ifdef RK_KBD_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMR_W-1:0] timer_q;

  assign timeout_s = (state_q != ST_IDLE) && (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  // Inter-byte timer: restarts on every strobe, idles at zero outside a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if (rx_stb || (state_q == ST_IDLE)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Frame parser next state and commit logic.
  always_comb begin
    state_d     = state_q;
    mod_d       = mod_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    err_d       = err_q;
    srst_d      = srst_q;
    matrix_d    = matrix_q;
    shift_d     = shift_q;
    k_reset_d   = k_reset_q;
    frame_err_d = 1'b0;
    if (rx_stb) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == HDR) begin
            state_d = ST_MOD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MOD: begin
          mod_d   = {rx_byte[MOD_LALT],
                     rx_byte[MOD_LCTRL] | rx_byte[MOD_RCTRL],
                     rx_byte[MOD_LSHIFT] | rx_byte[MOD_RSHIFT]};
          state_d = ST_RSVD;
        end
        ST_RSVD: begin
          shadow_d = '0;
          err_d    = 1'b0;
          srst_d   = 1'b0;
          slot_d   = '0;
          state_d  = ST_KEY;
        end
        ST_KEY: begin
          shadow_d = shadow_q | key_bits_s;
          if (rx_byte == ROLLOVER) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (rx_byte == KEY_F12) begin
            srst_d = 1'b1;
          end else begin
            srst_d = srst_q;
          end
          if (slot_q == LAST_SLOT) begin
            state_d = ST_IDLE;
            slot_d  = '0;
            // A rollover anywhere in the report leaves the visible state untouched.
            if (err_d) begin
              frame_err_d = 1'b1;
            end else begin
              matrix_d  = shadow_d;
              shift_d   = mod_q;
              k_reset_d = srst_d;
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout_s) begin
      state_d     = ST_IDLE;
      slot_d      = '0;
      frame_err_d = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mod_q       <= 3'b000;
      slot_q      <= '0;
      shadow_q    <= '0;
      err_q       <= 1'b0;
      srst_q      <= 1'b0;
      matrix_q    <= '0;
      shift_q     <= 3'b000;
      k_reset_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mod_q       <= mod_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      err_q       <= err_d;
      srst_q      <= srst_d;
      matrix_q    <= matrix_d;
      shift_q     <= shift_d;
      k_reset_q   <= k_reset_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Column read: OR of every selected row of the committed matrix.
  always_comb begin
    odata = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (addr[r]) begin
        odata = odata | matrix_q[r];
      end else begin
        odata = odata;
      end
    end
  end

  assign shift     = shift_q;
  assign k_reset   = k_reset_q;
  assign frame_err = frame_err_q;

endmodule
